// File: rtl/ext_mem_bridge_if.sv
// Bus side of the CPU-to-external-memory bridge: one strobed transaction at a time.
interface ext_mem_bridge_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // Handshake: bus_re/bus_we plays "valid" and bus_ack plays "ready". A strobe
  // holds bus_addr/bus_wdata stable until bus_ack is sampled high at a rising
  // edge, which completes the transfer (bus_rdata is taken on that edge for
  // reads). bus_ack while no strobe is high is ignored. At most one strobe at a time.
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_re;
  logic              bus_we;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  modport master (
    output bus_addr, bus_wdata, bus_re, bus_we,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_re, bus_we,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/ext_mem_bridge.sv
// Bridge from the CPU data-memory port to a variable-latency bus: posted write
// buffer, ack-handshaked reads, pipeline stall and a sticky bus timeout.
module ext_mem_bridge #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int WBUF_DEPTH = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic                        cpu_re,
  input  logic                        cpu_we,
  input  logic [DATA_W-1:0]           cpu_wdata,
  output logic [DATA_W-1:0]           cpu_rdata,
  output logic                        cpu_stall,
  ext_mem_bridge_if.master            bus,
  output logic                        err,
  output logic [ADDR_W-1:0]           err_addr,
  input  logic                        err_clr,
  output logic [1:0]                  dbg_state,
  output logic [$clog2(WBUF_DEPTH):0] dbg_count
);
  localparam int AW = $clog2(WBUF_DEPTH);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  state_t            state;
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic [ADDR_W-1:0] fifo_addr [WBUF_DEPTH];
  logic [DATA_W-1:0] fifo_data [WBUF_DEPTH];
  logic [CW-1:0]     cnt;
  logic              rd_done;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              busy;
  logic              timeout_hit;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full        = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty       = (wptr == rptr);
  assign push        = cpu_we && !cpu_re && !full;
  assign busy        = (state != ST_IDLE);
  assign timeout_hit = busy && !bus.bus_ack && (cnt == TO_LAST);
  assign pop         = (state == ST_WRITE) && (bus.bus_ack || timeout_hit);
  assign cpu_stall   = rst_n && ((cpu_re && !rd_done) || (cpu_we && !cpu_re && full));
  assign dbg_state   = state;
  assign dbg_count   = wptr - rptr;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wptr[AW-1:0]] <= cpu_addr;
      fifo_data[wptr[AW-1:0]] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      wptr          <= '0;
      rptr          <= '0;
      cnt           <= '0;
      rd_done       <= 1'b0;
      cpu_rdata     <= '0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_re    <= 1'b0;
      bus.bus_we    <= 1'b0;
      err           <= 1'b0;
      err_addr      <= '0;
    end else begin
      rd_done <= 1'b0;
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          // Buffered writes drain first so a later read sees their data.
          if (!empty) begin
            state         <= ST_WRITE;
            bus.bus_we    <= 1'b1;
            bus.bus_addr  <= fifo_addr[rptr[AW-1:0]];
            bus.bus_wdata <= fifo_data[rptr[AW-1:0]];
          end else if (cpu_re && !rd_done) begin
            state        <= ST_READ;
            bus.bus_re   <= 1'b1;
            bus.bus_addr <= cpu_addr;
          end
        end
        ST_WRITE, ST_READ: begin
          if (bus.bus_ack || timeout_hit) begin
            state      <= ST_IDLE;
            bus.bus_we <= 1'b0;
            bus.bus_re <= 1'b0;
            if (state == ST_READ) begin
              cpu_rdata <= bus.bus_ack ? bus.bus_rdata : '1;
              rd_done   <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          bus.bus_we <= 1'b0;
          bus.bus_re <= 1'b0;
        end
      endcase

      // A clear wins over a timeout in the same cycle; that error is dropped.
      if (err_clr) begin
        err      <= 1'b0;
        err_addr <= '0;
      end else if (timeout_hit) begin
        err <= 1'b1;
        if (!err) err_addr <= bus.bus_addr;
      end
    end
  end
endmodule

// File: tb/tb_ext_mem_bridge.sv
// Bench for ext_mem_bridge: read vector table, hand-written corner sequences and
// a randomized CPU program checked against a flat memory model and write-order queue.
module tb_ext_mem_bridge;
  localparam int TMO   = 8;
  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_addr;
  logic        cpu_re;
  logic        cpu_we;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_stall;
  logic        err;
  logic [15:0] err_addr;
  logic        err_clr;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_count;

  ext_mem_bridge_if #(.ADDR_W(16), .DATA_W(16)) bus_if ();

  ext_mem_bridge #(.DATA_W(16), .ADDR_W(16), .WBUF_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_addr  (cpu_addr),
    .cpu_re    (cpu_re),
    .cpu_we    (cpu_we),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .bus       (bus_if.master),
    .err       (err),
    .err_addr  (err_addr),
    .err_clr   (err_clr),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] init_val(input logic [7:0] a);
    case (a)
      8'h40:   return 16'h1234;
      8'h30:   return 16'h0777;
      default: return {a, ~a} ^ 16'h5A00;
    endcase
  endfunction

  // ---------------- bus responder ----------------
  logic [15:0] bus_mem [256];
  logic [31:0] obs_wq[$];
  int  strobe_n = 0, cur_delay = 0, last_len = 0;
  int  log_re_n = 0, log_we_n = 0, writes_acked = 0, order_err = 0;
  int  ack_delay_next = 0;   // -1: never acknowledge
  bit  ack_const = 1'b0;     // hold ack high every cycle
  int  writes_issued = 0;

  initial begin
    for (int i = 0; i < 256; i++) bus_mem[i] = init_val(8'(i));
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_if.bus_re || bus_if.bus_we) begin
        if (strobe_n == 0) begin
          cur_delay = ack_delay_next;
          if (bus_if.bus_re) begin
            log_re_n++;
            if (writes_issued != writes_acked) order_err++;
          end else begin
            log_we_n++;
          end
        end
        strobe_n++;
        bus_if.bus_rdata = bus_mem[bus_if.bus_addr[7:0]];
        bus_if.bus_ack   = ack_const || (cur_delay >= 0 && strobe_n == cur_delay + 1);
        if (bus_if.bus_ack && bus_if.bus_we) begin
          bus_mem[bus_if.bus_addr[7:0]] = bus_if.bus_wdata;
          obs_wq.push_back({bus_if.bus_addr, bus_if.bus_wdata});
          writes_acked++;
        end
      end else begin
        if (strobe_n != 0) last_len = strobe_n;
        strobe_n = 0;
        bus_if.bus_ack = ack_const;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          failures = 0;
  logic [15:0] ref_mem [256];
  logic [15:0] exp_q[$];
  logic [31:0] exp_wq[$];
  int          wq_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  task automatic check_writes();
    check("wr_count", obs_wq.size(), exp_wq.size());
    while (wq_idx < exp_wq.size() && wq_idx < obs_wq.size()) begin
      check("wr_order", obs_wq[wq_idx], exp_wq[wq_idx]);
      wq_idx++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cpu_op(input logic re, input logic we, input logic [15:0] a, input logic [15:0] d,
                        output int stalls, output logic [15:0] rd);
    cpu_re = re; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    if (we && !re) begin
      writes_issued++;
      exp_wq.push_back({a, d});
      ref_mem[a[7:0]] = d;
    end
    stalls = 0;
    #1;
    while (cpu_stall && stalls < 400) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (stalls >= 400) begin
      checks++; failures++;
      $display("FAIL stall_bound: stall still high after %0d cycles, addr 0x%0h", stalls, a);
    end
    rd = cpu_rdata;
    @(negedge clk);
    cpu_re = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic idle(input int n);
    cpu_re = 1'b0; cpu_we = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (writes_acked != writes_issued && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_acked", writes_acked, writes_issued);
    idle(2);
  endtask

  // ---------------- read vector table ----------------
  typedef struct {
    logic [15:0] addr;
    bit          hold;
    int          k;
    int          exp_stall;
    logic [15:0] exp_rdata;
  } rd_vec_t;

  rd_vec_t     vecs [5];
  int          st, re0, snap, op;
  logic [15:0] rd, a, d;

  initial begin
    cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; err_clr = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));

    vecs[0] = '{16'h0040, 1'b1, 0, 2, 16'h1234};
    vecs[1] = '{16'h0041, 1'b0, 0, 2, init_val(8'h41)};
    vecs[2] = '{16'h0042, 1'b0, 1, 3, init_val(8'h42)};
    vecs[3] = '{16'h0043, 1'b0, 3, 5, init_val(8'h43)};
    vecs[4] = '{16'h0044, 1'b0, 7, 9, init_val(8'h44)};

    // Reset state, with a read request asserted during reset.
    #2;
    cpu_re = 1'b1;
    #1;
    check("rst_stall", cpu_stall, 0);
    check("rst_bus_re", bus_if.bus_re, 0);
    check("rst_bus_we", bus_if.bus_we, 0);
    check("rst_bus_addr", bus_if.bus_addr, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_err", err, 0);
    check("rst_err_addr", err_addr, 0);
    check("rst_count", dbg_count, 0);
    cpu_re = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Read latency table.
    for (int i = 0; i < 5; i++) begin
      ack_const = vecs[i].hold;
      ack_delay_next = vecs[i].k;
      re0 = log_re_n;
      cpu_op(1'b1, 1'b0, vecs[i].addr, 16'h0, st, rd);
      check("rd_stall", st, vecs[i].exp_stall);
      check("rd_data", rd, vecs[i].exp_rdata);
      check("rd_pulses", log_re_n - re0, 1);
      check("rd_err", err, 0);
    end
    ack_const = 1'b0;
    idle(1);

    // Buffer full: third write waits for the first ack.
    ack_delay_next = 3;
    cpu_op(1'b0, 1'b1, 16'h0020, 16'hAAAA, st, rd);
    check("full_stall_a", st, 0);
    cpu_op(1'b0, 1'b1, 16'h0021, 16'hBBBB, st, rd);
    check("full_stall_b", st, 0);
    cpu_op(1'b0, 1'b1, 16'h0022, 16'hCCCC, st, rd);
    check("full_stall_c", st, 4);
    drain();
    check_writes();

    // Read-after-write to the same address.
    ack_delay_next = 3;
    cpu_op(1'b0, 1'b1, 16'h0010, 16'hBEEF, st, rd);
    cpu_op(1'b1, 1'b0, 16'h0010, 16'h0, st, rd);
    check("raw_data", rd, 16'hBEEF);
    check("raw_stall", st, 10);
    check("raw_order", order_err, 0);
    drain();
    check_writes();

    // Simultaneous read+write is a read only.
    ack_delay_next = 0;
    snap = log_we_n;
    cpu_op(1'b1, 1'b1, 16'h0030, 16'h5555, st, rd);
    check("rw_data", rd, 16'h0777);
    check("rw_stall", st, 2);
    idle(3);
    check("rw_no_write", log_we_n - snap, 0);
    check("rw_count", dbg_count, 0);
    cpu_op(1'b1, 1'b0, 16'h0030, 16'h0, st, rd);
    check("rw_mem_kept", rd, 16'h0777);

    // Push and pop in the same cycle at one entry.
    ack_const = 1'b1;
    cpu_op(1'b0, 1'b1, 16'h0031, 16'h1111, st, rd);
    @(negedge clk);
    cpu_we = 1'b1; cpu_addr = 16'h0032; cpu_wdata = 16'h2222;
    writes_issued++;
    exp_wq.push_back({16'h0032, 16'h2222});
    ref_mem[8'h32] = 16'h2222;
    #1;
    check("pp_count_before", dbg_count, 1);
    check("pp_bus_we", bus_if.bus_we, 1);
    check("pp_stall", cpu_stall, 0);
    @(negedge clk);
    cpu_we = 1'b0;
    #1;
    check("pp_count_after", dbg_count, 1);
    ack_const = 1'b0;
    ack_delay_next = 0;
    drain();
    check_writes();

    // Timeouts and sticky error capture.
    ack_delay_next = -1;
    cpu_op(1'b1, 1'b0, 16'h00A0, 16'h0, st, rd);
    check("to_stall", st, TMO + 1);
    check("to_rdata", rd, 16'hFFFF);
    check("to_strobe_len", last_len, TMO);
    check("to_err", err, 1);
    check("to_err_addr", err_addr, 16'h00A0);
    cpu_op(1'b1, 1'b0, 16'h00B0, 16'h0, st, rd);
    check("to2_rdata", rd, 16'hFFFF);
    check("to2_err", err, 1);
    check("to2_err_addr", err_addr, 16'h00A0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    check("clr_err", err, 0);
    check("clr_err_addr", err_addr, 0);
    cpu_op(1'b1, 1'b0, 16'h00C0, 16'h0, st, rd);
    check("to3_err_addr", err_addr, 16'h00C0);

    // Reset in the middle of a write with two entries buffered.
    cpu_op(1'b0, 1'b1, 16'h0080, 16'h8080, st, rd);
    check("rw0_stall", st, 0);
    cpu_op(1'b0, 1'b1, 16'h0081, 16'h8181, st, rd);
    check("rw1_stall", st, 0);
    #1;
    check("mid_bus_we", bus_if.bus_we, 1);
    check("mid_count", dbg_count, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bus_we", bus_if.bus_we, 0);
    check("mid_rst_count", dbg_count, 0);
    check("mid_rst_err", err, 0);
    writes_issued -= 2;
    void'(exp_wq.pop_back());
    void'(exp_wq.pop_back());
    ref_mem[8'h80] = init_val(8'h80);
    ref_mem[8'h81] = init_val(8'h81);
    @(negedge clk);
    rst_n = 1'b1;
    snap = log_re_n + log_we_n;
    ack_delay_next = 0;
    idle(6);
    check("post_rst_quiet", log_re_n + log_we_n, snap);
    check("post_rst_count", dbg_count, 0);
    check("post_rst_state", dbg_state, 0);
    check("post_rst_err", err, 0);

    // Randomized CPU program against the flat memory model.
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 9);
      a = 16'($urandom_range(0, 15));
      d = 16'($urandom);
      ack_delay_next = $urandom_range(0, 3);
      if (op <= 3) begin
        cpu_op(1'b0, 1'b1, a, d, st, rd);
      end else if (op <= 7) begin
        exp_q.push_back(ref_mem[a[7:0]]);
        cpu_op(1'b1, op == 7, a, d, st, rd);
        check("rand_rd", rd, exp_q.pop_front());
      end else begin
        idle(1);
      end
    end
    drain();
    check_writes();
    check("rand_order", order_err, 0);
    check("rand_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ext_mem_bridge.md
# ext_mem_bridge

Parametrised bridge between the pipelined CPU's data-memory port and an external memory/peripheral bus with variable latency. It adds four things the CPU's direct single-cycle `addr_out`/`we_out`/`re_out` path lacks: posted writes through a write buffer, wait-state reads via an `ack` handshake, a stall back to the pipeline, and a bus timeout with sticky error capture. It sits between the CPU's external DM interface and the SRAM/MMIO fabric.

## Interface
- `DATA_W`, default 16: data width.
- `ADDR_W`, default 16: address width.
- `WBUF_DEPTH`, default 2: write-buffer entries; must be a power of 2 and ≥2.
- `TIMEOUT`, default 255: number of cycles a bus strobe may wait for `bus_ack` before the transaction is aborted; must be ≥1.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `cpu_addr` in ADDR_W: request address.
- `cpu_re` in 1: read request.
- `cpu_we` in 1: write request.
- `cpu_wdata` in DATA_W: write data.
- `cpu_rdata` out DATA_W: read data. Registered; valid in the cycle `cpu_stall` falls after a read.
- `cpu_stall` out 1: freeze the pipeline. Combinational.
- `bus_addr` out ADDR_W: bus address. Registered.
- `bus_wdata` out DATA_W: bus write data. Registered.
- `bus_re` out 1: bus read strobe. Registered.
- `bus_we` out 1: bus write strobe. Registered.
- `bus_rdata` in DATA_W: bus read data; sampled only when `bus_ack` is high.
- `bus_ack` in 1: transaction complete.
- `err` out 1: sticky timeout flag.
- `err_addr` out ADDR_W: address of the first timed-out transaction.
- `err_clr` in 1: synchronous clear of `err` and `err_addr`.

## Operation
- Write buffer: a circular FIFO with log2(WBUF_DEPTH)+1-bit read/write pointers that wrap naturally.
  - Full: pointer MSBs differ and the low bits are equal.
  - Empty: the pointers are equal.
- FSM states:
  - IDLE → WRITE: FIFO non-empty. Writes have priority.
  - IDLE → READ: FIFO empty and `cpu_re` && !`rd_done`.
  - WRITE/READ → IDLE: `bus_ack` is sampled high, or the timeout counter reaches TIMEOUT.
- Push: at the clock edge when `cpu_we` && !`cpu_re` && !full.
  - Push and pop in the same cycle are allowed when the FIFO is not full.
  - Fullness is evaluated before the pop: a full FIFO stalls even if a pop happens that cycle.
- WRITE state:
  - `bus_we`=1, with `bus_addr`/`bus_wdata` taken from the FIFO head.
  - On ack: pop the head, drop `bus_we`, return to IDLE.
- READ state:
  - `bus_re`=1, `bus_addr`=`cpu_addr`.
  - On ack: capture `bus_rdata` into `cpu_rdata` and set the one-cycle `rd_done` pulse.
- Read ordering: a read launches only after the FIFO is empty and the bus is in IDLE. Reads therefore always observe earlier posted writes.
- `cpu_stall` = (`cpu_re` && !`rd_done`) || (`cpu_we` && !`cpu_re` && full).
- `cpu_re` and `cpu_we` high together: treated as a read only. The write is discarded and no error is raised.
- Timeout: the counter clears on entry to WRITE/READ and increments each cycle without ack. When it reaches TIMEOUT:
  - Drop the strobe and return to IDLE.
  - A write pops its entry; a read returns all-ones and pulses `rd_done`.
  - Set `err`. Load `err_addr` only if `err` was 0.
- `err_clr` has priority over a same-cycle new error. The error is lost and the team accepts that.
- The CPU holds `cpu_addr`/`cpu_re`/`cpu_we`/`cpu_wdata` stable while `cpu_stall`=1.

## Timing
- Reset: all registered outputs are 0; FIFO empty; FSM in IDLE; counter 0. `cpu_stall`=0 while `rst_n`=0.
- Reset mid-transaction: strobes drop asynchronously, and buffered writes are lost.
- Read, ack arriving k cycles after `bus_re` rises (k≥0):
  - Edge 0 samples `cpu_re`; `bus_re` is high from cycle 1.
  - Ack is sampled at the edge ending cycle 1+k.
  - `cpu_stall` is low and `cpu_rdata` valid in cycle 2+k.
  - Total stall is 2+k cycles.
- Write: zero stall when the FIFO is not full. The bus sees `bus_we` one cycle after the push.
- Back-to-back bus transactions have at least one idle cycle between them.
- Timeout abort: the strobe is high for exactly TIMEOUT cycles.

## Test plan
- Zero-wait read: `bus_ack`=1 throughout, read 0x0040 with `bus_rdata`=0x1234 → `cpu_stall` high for 2 cycles; `cpu_rdata`=0x1234 in the third cycle; exactly one `bus_re` pulse.
- Buffer full: WBUF_DEPTH=2, ack held low, three consecutive writes → the first two do not stall, the third stalls until the first ack. Bus writes appear in order A, B, C.
- Read-after-write: write 0x0010←0xBEEF, then immediately read 0x0010 with a 3-cycle ack delay → `bus_we` completes before `bus_re` rises; `cpu_rdata` = bus data.
- Timeout: TIMEOUT=8, read 0x00A0 with no ack → `bus_re` high for 8 cycles; `cpu_rdata`=0xFFFF; `err`=1; `err_addr`=0x00A0. A second timeout at 0x00B0 leaves `err_addr` unchanged. `err_clr` → 0.
- Reset mid-WRITE with 2 entries buffered → `bus_we` low immediately. After release: FIFO empty, `err`=0, no bus activity.
- Simultaneous `cpu_re`+`cpu_we`, and push/pop at 1 entry with ack=1 → read only with no FIFO push; occupancy stays at 1 across the push/pop cycle.
